ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage directly downstream of the ID/EX pipeline register.
- Consumes the decoded operands and controls, computes the ALU result or memory address, and resolves branch/JAL/JALR redirects combinationally.
- Registers its results into the EX/MEM boundary for the memory stage.
- Shifts use an iterative shifter (one bit per cycle) and stall the upstream pipeline while they run.

Parameters:
- XLEN, 64, datapath width.
- PCW, 8, program-counter width; byte address.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-low reset
WRegEn_in  in  1  register write enable from ID/EX
WMemEn_in  in  1  memory write enable (store)
mem_to_reg_in  in  1  load
rs2_swch_in  in  1  1 = operand B is sign_ext_in, 0 = R2out_in
R1out_in  in  XLEN  rs1 value
R2out_in  in  XLEN  rs2 value / store data
sign_ext_in  in  XLEN  immediate
WReg1_in  in  5  destination register
func3_in  in  3  funct3
func7_in  in  1  funct7[5]
jal_in, jalr_in, br_in  in  1 each  control-flow type
pc_in  in  PCW  instruction PC
stall_out  out  1  hold ID/EX and its inputs; combinational
redirect_out  out  1  taken branch/jump; flush IF/ID and ID/EX; combinational
target_out  out  PCW  redirect target; combinational
WRegEn_out, WMemEn_out, mem_to_reg_out  out  1 each  registered controls
alu_out  out  XLEN  result / address / link value
store_data_out  out  XLEN  registered R2out_in
WReg1_out  out  5  registered destination
func3_out  out  3  registered funct3, used as load/store size

Behaviour:
- **Reset.** RST low clears all registered outputs to 0 asynchronously and returns the FSM to IDLE with the shift counter at 0. Reset during a shift abandons it. stall_out is 0 during reset.
- **Operands.**
  - A = R1out_in.
  - B = rs2_swch_in ? sign_ext_in : R2out_in.
- **Loads and stores** (mem_to_reg_in or WMemEn_in): alu_out = A + sign_ext_in, ignoring func3_in.
- **ALU by func3_in:**
  - 000: ADD, or SUB when func7_in = 1 and rs2_swch_in = 0.
  - 001: SLL.
  - 010: SLT, signed.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when func7_in = 1.
  - 110: OR.
  - 111: AND.
  - SLT/SLTU produce a zero-extended 1-bit result. Arithmetic wraps modulo 2^XLEN.
- **JAL/JALR.**
  - alu_out = zero-extended (pc_in + 4), modulo 2^PCW.
  - JAL target = pc_in + sign_ext_in[PCW-1:0].
  - JALR target = (A + sign_ext_in)[PCW-1:0] with bit 0 cleared.
  - redirect_out = 1.
- **Branch** (br_in): compare R1 vs R2 by func3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 are never taken.
  - Taken: redirect_out = 1, target = pc_in + sign_ext_in[PCW-1:0].
  - WRegEn is forced to 0 for branches.
- **Latency.** Non-shift instructions take 1 cycle: inputs at edge N appear on the outputs after edge N+1.
- **Shift FSM**, states IDLE and SHIFT, amount n = B[5:0]:
  - IDLE with shift and n ≤ 1: single cycle, stall_out = 0.
  - IDLE with shift and n ≥ 2: stall_out = 1 combinationally. The edge loads the work register (1-bit pre-shifted) and count = n-1, then moves to SHIFT. The output register captures a bubble: all enables 0, data held.
  - SHIFT: one bit per cycle, count decrements. stall_out = (count > 1). When count = 1, the final result is written with the instruction's controls and the FSM returns to IDLE.
  - Total latency for a shift of n is n cycles, with stall_out high for n-1 of them.
- **Upstream contract.** Upstream holds all *_in stable while stall_out = 1. redirect_out is 0 in SHIFT.
- **Bubble.** All-zero controls propagate as a bubble.

Optional Feature:
- EX_BARREL_SHIFT_EN
  - Defined: a combinational barrel shifter replaces the FSM. Every shift takes 1 cycle and stall_out is tied to 0.
  - Undefined: the iterative behaviour above applies.

Decomposition:
- Package ex_pkg holds:
  - func3 encodings for ALU and branch operations;
  - the FSM state enum {IDLE, SHIFT};
  - the link-increment constant 4.
- Sub-module ex_shifter: work register, counter, FSM and stall, with ports start, amount, dir, arith, operand, busy, done, result. It is excluded when EX_BARREL_SHIFT_EN is defined.

Test Plan:
- ADD: R1=5, R2=7, func3=000, func7=0, rs2_swch=0, WRegEn=1, WReg1=3 -> next cycle alu_out=12, WRegEn_out=1, WReg1_out=3.
- SUB wrap: R1=0, R2=1, func7=1 -> alu_out=0xFFFF_FFFF_FFFF_FFFF. SLTU with the same operands -> 1.
- BLT taken: R1=-1, R2=0, br=1, func3=100, pc=0x40, imm=-8 -> same cycle redirect_out=1, target_out=0x38, WRegEn_out=0.
- JALR: pc=0xFC, R1=0x13, imm=2 -> target_out=0x14, alu_out=0x00 (link wraps).
- SRA: R1=0x8000_0000_0000_0000, imm=4, rs2_swch=1, func3=101, func7=1 -> stall_out high for 3 cycles, then alu_out=0xF800_0000_0000_0000. Bubble outputs while stalled. With EX_BARREL_SHIFT_EN: 1 cycle, no stall.
- Reset: RST low during SHIFT -> outputs 0 and stall_out 0 immediately. After release, an ADD completes in 1 cycle.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings and constants for the execute stage.
//   - funct3 encodings for ALU and branch operations
//   - state_t: iterative shifter FSM states {IDLE, SHIFT}
//   - LINK_INC: increment applied to the PC for JAL/JALR link values
//   - SHAMT_W: width of the shift amount taken from operand B
package ex_pkg;

    // ALU operations selected by funct3
    localparam logic [2:0] F3_ADD  = 3'b000;  // ADD / SUB
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;  // SRL / SRA
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch conditions selected by funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int LINK_INC = 4;
    localparam int SHAMT_W  = 6;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    function automatic logic is_shift_op(input logic [2:0] func3);
        return (func3 == F3_SLL) || (func3 == F3_SR);
    endfunction

endpackage

// File: rtl/ex_if.sv
// ex_if: bundle of the ID/EX inputs and EX/MEM outputs of the execute stage.
//   master modport: upstream/memory side (drives *_in, observes outputs)
//   slave  modport: ex_stage itself
interface ex_if #(
    parameter int XLEN = 64,
    parameter int PCW  = 8
);
    // From ID/EX
    logic            WRegEn_in;
    logic            WMemEn_in;
    logic            mem_to_reg_in;
    logic            rs2_swch_in;
    logic [XLEN-1:0] R1out_in;
    logic [XLEN-1:0] R2out_in;
    logic [XLEN-1:0] sign_ext_in;
    logic [4:0]      WReg1_in;
    logic [2:0]      func3_in;
    logic            func7_in;
    logic            jal_in;
    logic            jalr_in;
    logic            br_in;
    logic [PCW-1:0]  pc_in;

    // Combinational hazard / redirect outputs
    logic            stall_out;
    logic            redirect_out;
    logic [PCW-1:0]  target_out;

    // EX/MEM register
    logic            WRegEn_out;
    logic            WMemEn_out;
    logic            mem_to_reg_out;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] store_data_out;
    logic [4:0]      WReg1_out;
    logic [2:0]      func3_out;

    modport master (
        output WRegEn_in, WMemEn_in, mem_to_reg_in, rs2_swch_in,
               R1out_in, R2out_in, sign_ext_in, WReg1_in, func3_in, func7_in,
               jal_in, jalr_in, br_in, pc_in,
        input  stall_out, redirect_out, target_out,
               WRegEn_out, WMemEn_out, mem_to_reg_out, alu_out,
               store_data_out, WReg1_out, func3_out
    );

    modport slave (
        input  WRegEn_in, WMemEn_in, mem_to_reg_in, rs2_swch_in,
               R1out_in, R2out_in, sign_ext_in, WReg1_in, func3_in, func7_in,
               jal_in, jalr_in, br_in, pc_in,
        output stall_out, redirect_out, target_out,
               WRegEn_out, WMemEn_out, mem_to_reg_out, alu_out,
               store_data_out, WReg1_out, func3_out
    );
endinterface

// File: rtl/ex_shifter.sv
// ex_shifter: iterative one-bit-per-cycle shifter used for shifts of 2 or more.
//   CLK, RST   : clock, asynchronous active-low reset
//   start      : a shift instruction is presented (held stable while busy)
//   amount     : shift amount
//   dir        : 1 = right, 0 = left
//   arith      : right shifts replicate the sign bit
//   operand    : value to shift
//   busy       : upstream must stall (combinational)
//   done       : final result is on result this cycle
//   result     : shifted value, valid when done
// Not instantiated when EX_BARREL_SHIFT_EN is defined.
module ex_shifter
    import ex_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic [SHAMT_W-1:0] amount,
    input  logic               dir,
    input  logic               arith,
    input  logic [XLEN-1:0]    operand,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    result
);

    state_t             state, state_next;
    logic [XLEN-1:0]    work, work_next;
    logic [SHAMT_W-1:0] count, count_next;
    logic [XLEN-1:0]    src, stepped;

    // The first bit is taken while loading, so the work register always
    // holds a partially shifted value and count is the bits still to go.
    assign src     = (state == IDLE) ? operand : work;
    assign stepped = dir ? {arith & src[XLEN-1], src[XLEN-1:1]}
                         : {src[XLEN-2:0], 1'b0};
    assign result  = stepped;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_next = state;
        work_next  = work;
        count_next = count;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start && (amount >= SHAMT_W'(2))) begin
                    busy       = 1'b1;
                    work_next  = stepped;
                    count_next = amount - SHAMT_W'(1);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                work_next  = stepped;
                count_next = count - SHAMT_W'(1);
                if (count > SHAMT_W'(1)) begin
                    busy = 1'b1;
                end else begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // NOTE: the work register is reset too; its content is don't-care in IDLE
    // but resetting it keeps X out of simulation at negligible cost.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            work  <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            work  <= work_next;
            count <= count_next;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage between the ID/EX and EX/MEM pipeline registers.
//   CLK, RST : clock, asynchronous active-low reset
//   bus      : ex_if.slave -- ID/EX operands and controls in; combinational
//              stall/redirect/target out; registered EX/MEM results out.
// Computes ALU results, load/store addresses and JAL/JALR link values,
// resolves branches and jumps combinationally, and registers the results.
// Build option EX_BARREL_SHIFT_EN: single-cycle barrel shifts, no stall.
// Without it, shifts of 2 or more run in ex_shifter and stall upstream.
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PCW  = 8
) (
    input  logic CLK,
    input  logic RST,
    ex_if.slave  bus
);

    logic [XLEN-1:0]    op_a, op_b;
    logic [SHAMT_W-1:0] shamt;
    logic               is_mem, is_jump, shift_instr, do_sub;
    logic [XLEN-1:0]    sll_val, srl_val, sra_val;
    logic [XLEN-1:0]    alu_result, ex_result;
    logic [PCW-1:0]     link_pc, jalr_target, rel_target;
    logic               taken;
    logic               stall_int;

    assign op_a  = bus.R1out_in;
    assign op_b  = bus.rs2_swch_in ? bus.sign_ext_in : bus.R2out_in;
    assign shamt = op_b[SHAMT_W-1:0];

    assign is_mem      = bus.mem_to_reg_in | bus.WMemEn_in;
    assign is_jump     = bus.jal_in | bus.jalr_in;
    assign shift_instr = !is_mem && !is_jump && !bus.br_in && is_shift_op(bus.func3_in);
    // Immediate forms never subtract: funct7[5] is part of the immediate there.
    assign do_sub      = bus.func7_in & ~bus.rs2_swch_in;

`ifdef EX_BARREL_SHIFT_EN
    assign sll_val   = op_a << shamt;
    assign srl_val   = op_a >> shamt;
    assign sra_val   = XLEN'($signed(op_a) >>> shamt);
    assign stall_int = 1'b0;
`else
    logic            shift_busy, shift_done;
    logic [XLEN-1:0] shift_result;

    // Only amounts of 0 or 1 finish here; longer shifts come from ex_shifter.
    assign sll_val = shamt[0] ? {op_a[XLEN-2:0], 1'b0} : op_a;
    assign srl_val = shamt[0] ? {1'b0, op_a[XLEN-1:1]} : op_a;
    assign sra_val = shamt[0] ? {op_a[XLEN-1], op_a[XLEN-1:1]} : op_a;

    ex_shifter #(.XLEN(XLEN)) u_shifter (
        .CLK     (CLK),
        .RST     (RST),
        .start   (shift_instr),
        .amount  (shamt),
        .dir     (bus.func3_in == F3_SR),
        .arith   (bus.func7_in),
        .operand (op_a),
        .busy    (shift_busy),
        .done    (shift_done),
        .result  (shift_result)
    );

    assign stall_int = shift_busy;
`endif

    // Inputs may still present a shift while RST is low; never stall in reset.
    assign bus.stall_out = stall_int & RST;

    always_comb begin
        alu_result = '0;
        case (bus.func3_in)
            F3_ADD:  alu_result = do_sub ? (op_a - op_b) : (op_a + op_b);
            F3_SLL:  alu_result = sll_val;
            F3_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            F3_SLTU: alu_result = {{(XLEN-1){1'b0}}, op_a < op_b};
            F3_XOR:  alu_result = op_a ^ op_b;
            F3_SR:   alu_result = bus.func7_in ? sra_val : srl_val;
            F3_OR:   alu_result = op_a | op_b;
            F3_AND:  alu_result = op_a & op_b;
            default: alu_result = '0;
        endcase
    end

    assign link_pc = bus.pc_in + PCW'(LINK_INC);

    always_comb begin
        if (is_jump)
            ex_result = {{(XLEN-PCW){1'b0}}, link_pc};
        else if (is_mem)
            ex_result = op_a + bus.sign_ext_in;
        else
            ex_result = alu_result;
`ifndef EX_BARREL_SHIFT_EN
        if (shift_done)
            ex_result = shift_result;
`endif
    end

    // Branches compare the register values, never the immediate.
    always_comb begin
        taken = 1'b0;
        case (bus.func3_in)
            F3_BEQ:  taken = bus.R1out_in == bus.R2out_in;
            F3_BNE:  taken = bus.R1out_in != bus.R2out_in;
            F3_BLT:  taken = $signed(bus.R1out_in) <  $signed(bus.R2out_in);
            F3_BGE:  taken = $signed(bus.R1out_in) >= $signed(bus.R2out_in);
            F3_BLTU: taken = bus.R1out_in <  bus.R2out_in;
            F3_BGEU: taken = bus.R1out_in >= bus.R2out_in;
            default: taken = 1'b0;
        endcase
    end

    assign rel_target  = bus.pc_in + bus.sign_ext_in[PCW-1:0];
    // Only the low PCW bits of rs1 + imm matter for the target.
    assign jalr_target = (op_a[PCW-1:0] + bus.sign_ext_in[PCW-1:0]) & ~PCW'(1);

    assign bus.redirect_out = is_jump | (bus.br_in & taken);
    assign bus.target_out   = bus.jalr_in ? jalr_target : rel_target;

    // While stalled the register captures a bubble: enables drop, data holds.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.WRegEn_out     <= 1'b0;
            bus.WMemEn_out     <= 1'b0;
            bus.mem_to_reg_out <= 1'b0;
            bus.alu_out        <= '0;
            bus.store_data_out <= '0;
            bus.WReg1_out      <= '0;
            bus.func3_out      <= '0;
        end else if (stall_int) begin
            bus.WRegEn_out     <= 1'b0;
            bus.WMemEn_out     <= 1'b0;
            bus.mem_to_reg_out <= 1'b0;
        end else begin
            bus.WRegEn_out     <= bus.WRegEn_in & ~bus.br_in;
            bus.WMemEn_out     <= bus.WMemEn_in;
            bus.mem_to_reg_out <= bus.mem_to_reg_in;
            bus.alu_out        <= ex_result;
            bus.store_data_out <= bus.R2out_in;
            bus.WReg1_out      <= bus.WReg1_in;
            bus.func3_out      <= bus.func3_in;
        end
    end

endmodule
